// File: rtl/core_irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, widths and source limit.
package core_irq_ctrl_pkg;

    localparam int REG_W     = 16;
    localparam int ADDR_W    = 3;
    localparam int IDX_W     = 4;
    localparam int N_SRC_MAX = 15;

    localparam logic [ADDR_W-1:0] ADDR_PENDING  = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_MODE     = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_ACTIVE   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_VECTOR   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_FORCE    = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_OVERFLOW = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_RSVD     = 3'd7;

endpackage

// File: rtl/core_irq_ctrl_if.sv
// Avalon-MM style register bus between a CPU-side master and the interrupt controller.
interface core_irq_ctrl_if;
    import core_irq_ctrl_pkg::*;

    logic              chipselect;
    logic              write_n;
    logic [ADDR_W-1:0] address;
    logic [REG_W-1:0]  writedata;
    logic [REG_W-1:0]  readdata;

    modport master (
        output chipselect,
        output write_n,
        output address,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  write_n,
        input  address,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/core_irq_prio_enc.sv
// Combinational lowest-index-first priority encoder over the active interrupt vector.
module core_irq_prio_enc
    import core_irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 5
) (
    input  logic [N_SRC-1:0] active,
    output logic [IDX_W-1:0] index,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one to win.
    always_comb begin
        index = '0;
        valid = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                index = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_irq_ctrl.sv
// Interrupt controller: per-source edge/level capture, pending/mask/overflow registers,
// lowest-index vector and a registered aggregate interrupt to the CPU.
module core_irq_ctrl
    import core_irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    core_irq_ctrl_if.slave   bus,
    output logic             irq_out
);

    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] mode;
    logic [N_SRC-1:0] overflow;
    logic [N_SRC-1:0] irq_d;

    logic             wr;
    logic [N_SRC-1:0] wr_data;
    logic [N_SRC-1:0] edge_evt;
    logic [N_SRC-1:0] level_evt;
    logic [N_SRC-1:0] force_set;
    logic [N_SRC-1:0] pend_clr;
    logic [N_SRC-1:0] ovf_clr;
    logic [N_SRC-1:0] ovf_set;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] pending_next;
    logic [N_SRC-1:0] overflow_next;
    logic [IDX_W-1:0] vec_index;
    logic             vec_valid;
    logic [REG_W-1:0] vector;
    logic [REG_W-1:0] rd_mux;
    logic             unused_wdata;

    assign wr           = bus.chipselect && !bus.write_n;
    assign wr_data      = bus.writedata[N_SRC-1:0];
    assign unused_wdata = ^bus.writedata[REG_W-1:N_SRC];

    assign edge_evt  = irq_in & ~irq_d & ~mode;
    assign level_evt = irq_in & mode;
    assign force_set = (wr && bus.address == ADDR_FORCE)    ? wr_data : '0;
    assign pend_clr  = (wr && bus.address == ADDR_PENDING)  ? wr_data : '0;
    assign ovf_clr   = (wr && bus.address == ADDR_OVERFLOW) ? wr_data : '0;

    // Sets are ORed in after the clear so an event always beats a same-cycle W1C.
    assign ovf_set       = edge_evt & pending & ~pend_clr;
    assign pending_next  = (pending & ~pend_clr) | edge_evt | level_evt | force_set;
    assign overflow_next = (overflow & ~ovf_clr) | ovf_set;

    assign active = pending & mask;

    core_irq_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .active (active),
        .index  (vec_index),
        .valid  (vec_valid)
    );

    assign vector = vec_valid ? {1'b1, {(REG_W - 1 - IDX_W){1'b0}}, vec_index} : '0;

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_PENDING:  rd_mux = REG_W'(pending);
            ADDR_MASK:     rd_mux = REG_W'(mask);
            ADDR_MODE:     rd_mux = REG_W'(mode);
            ADDR_ACTIVE:   rd_mux = REG_W'(active);
            ADDR_VECTOR:   rd_mux = vector;
            ADDR_OVERFLOW: rd_mux = REG_W'(overflow);
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            mask         <= '0;
            mode         <= '0;
            overflow     <= '0;
            irq_d        <= '0;
            bus.readdata <= '0;
            irq_out      <= 1'b0;
        end else begin
            irq_d        <= irq_in;
            pending      <= pending_next;
            overflow     <= overflow_next;
            bus.readdata <= rd_mux;
            irq_out      <= |active;
            if (wr && bus.address == ADDR_MASK) mask <= wr_data;
            if (wr && bus.address == ADDR_MODE) mode <= wr_data;
        end
    end

endmodule
